// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by the fetch top and its redirect controller.
package fetch_unit_pkg;

  localparam int XLEN_P = 32;
  localparam int INST_BYTES = 4;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FULL
  } fetch_state_e;

  typedef struct packed {
    logic              valid;
    logic [XLEN_P-1:0] target;
  } redir_t;

endpackage

// File: rtl/fetch_unit_redirect_ctrl.sv
// Turns execute's resolved control transfer into a fetch redirect,
// or flags it as a misaligned target for the trap unit.
module redirect_ctrl
  import fetch_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic            take_branch,
  input  logic [XLEN-1:0] ex_target,
  output redir_t          redir,
  output logic            bad_target
);

  logic transfer;
  logic aligned;

  assign transfer = ex_valid & (ex_is_jump | (ex_is_branch & take_branch));
  assign aligned  = (ex_target[1:0] == 2'b00);

  assign redir.valid  = transfer & aligned;
  assign redir.target = {ex_target[XLEN-1:2], 2'b00};
  assign bad_target   = transfer & ~aligned;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, one outstanding imem request,
// one-entry buffer towards decode, redirect on taken control flow.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic            take_branch,
  input  logic [XLEN-1:0] ex_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_inst,
  output logic            if_flush,
  output logic            fetch_misaligned,
  output logic [XLEN-1:0] misaligned_addr
);

  localparam logic [XLEN-1:0] STEP = XLEN'(INST_BYTES);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] if_pc_q;
  logic [31:0]     if_inst_q;
  logic            mis_q;
  logic [XLEN-1:0] mis_addr_q;
  logic            load_buf;
  logic            req_fire;
  redir_t          redir;
  logic            bad_target;

  redirect_ctrl #(.XLEN(XLEN)) u_redirect (
    .ex_valid     (ex_valid),
    .ex_is_branch (ex_is_branch),
    .ex_is_jump   (ex_is_jump),
    .take_branch  (take_branch),
    .ex_target    (ex_target),
    .redir        (redir),
    .bad_target   (bad_target)
  );

  assign imem_req_valid   = (state_q == S_REQ);
  assign imem_req_addr    = pc_q;
  assign req_fire         = imem_req_valid & imem_req_ready;
  assign if_valid         = (state_q == S_FULL);
  assign if_pc            = if_pc_q;
  assign if_inst          = if_inst_q;
  assign if_flush         = redir.valid;
  assign fetch_misaligned = mis_q;
  assign misaligned_addr  = mis_addr_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    drop_d   = drop_q;
    load_buf = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (req_fire) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + STEP;
          drop_d   = redir.valid;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          drop_d = 1'b0;
          if (drop_q | redir.valid) begin
            state_d = S_REQ;
          end else begin
            load_buf = 1'b1;
            state_d  = S_FULL;
          end
        end else if (redir.valid) begin
          drop_d = 1'b1;
        end
      end
      S_FULL: begin
        // a redirect voids any same-cycle decode handshake
        if (redir.valid | if_ready) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
    if (redir.valid) pc_d = redir.target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      drop_q     <= 1'b0;
      if_pc_q    <= '0;
      if_inst_q  <= NOP_INST;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
      mis_q    <= bad_target;
      if (load_buf) begin
        if_pc_q   <= req_pc_q;
        if_inst_q <= imem_resp_data;
      end
      if (bad_target) mis_addr_q <= ex_target;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic,
// scored against a transaction-level fetch/redirect model.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        ex_valid, ex_is_branch, ex_is_jump, take_branch;
  logic [31:0] ex_target;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_inst;
  logic        if_flush, fetch_misaligned;
  logic [31:0] misaligned_addr;

  fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .ex_valid         (ex_valid),
    .ex_is_branch     (ex_is_branch),
    .ex_is_jump       (ex_is_jump),
    .take_branch      (take_branch),
    .ex_target        (ex_target),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_resp_valid  (imem_resp_valid),
    .imem_resp_data   (imem_resp_data),
    .if_valid         (if_valid),
    .if_ready         (if_ready),
    .if_pc            (if_pc),
    .if_inst          (if_inst),
    .if_flush         (if_flush),
    .fetch_misaligned (fetch_misaligned),
    .misaligned_addr  (misaligned_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          drop;
  } ent_t;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  ent_t        q[$];
  logic [31:0] dq_pc[$];
  int          dq_cyc[$];
  int          cyc = 0;
  int          n_deliv = 0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] mis_exp = 32'h0;
  bit          bad_prev = 0;
  bit          p_hold_if = 0;
  bit          p_hold_req = 0;
  logic [31:0] p_pc, p_inst;

  int          mem_wait = 0;
  int          mem_lat = 1;
  logic [31:0] mem_addr = 32'h0;
  bit          hold_rdy = 0;
  bit          rdy_rand = 0;

  bit          rst_v = 1;
  bit          ifr_v = 1;
  bit          nx_valid = 0, nx_br = 0, nx_jmp = 0, nx_take = 0;
  logic [31:0] nx_tgt = 32'h0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic monitor();
    bit ctl, redir, bad;
    cyc++;
    if (rst) begin
      exp_pc = 32'h0;
      q.delete();
      mis_exp = 32'h0;
      bad_prev = 0;
      p_hold_if = 0;
      p_hold_req = 0;
      return;
    end
    ctl   = ex_valid && (ex_is_jump || (ex_is_branch && take_branch));
    redir = ctl && (ex_target[1:0] == 2'b00);
    bad   = ctl && (ex_target[1:0] != 2'b00);
    check("flush", 32'(if_flush), 32'(redir));
    check("mis_pulse", 32'(fetch_misaligned), 32'(bad_prev));
    check("mis_addr", misaligned_addr, mis_exp);
    if (if_valid) check("req_in_full", 32'(imem_req_valid), 32'h0);
    if (p_hold_if) begin
      check("hold_valid", 32'(if_valid), 32'h1);
      check("hold_pc", if_pc, p_pc);
      check("hold_inst", if_inst, p_inst);
    end
    if (p_hold_req) check("req_hold", 32'(imem_req_valid), 32'h1);
    if (imem_req_valid) check("req_addr", imem_req_addr, exp_pc);
    if (imem_req_valid && imem_req_ready) begin
      q.push_back('{addr: exp_pc, drop: 1'b0});
      mem_addr = imem_req_addr;
      mem_wait = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
      exp_pc = exp_pc + 32'd4;
    end
    if (if_valid && if_ready && !redir) begin
      while (q.size() > 0 && q[0].drop) void'(q.pop_front());
      if (q.size() == 0) begin
        check("deliv_qlen", 32'(q.size()), 32'h1);
      end else begin
        check("deliv_pc", if_pc, q[0].addr);
        check("deliv_inst", if_inst, mem_word(q[0].addr));
        void'(q.pop_front());
      end
      dq_pc.push_back(if_pc);
      dq_cyc.push_back(cyc);
      n_deliv++;
    end
    if (redir) begin
      foreach (q[i]) q[i].drop = 1;
      exp_pc = {ex_target[31:2], 2'b00};
    end
    if (bad) mis_exp = ex_target;
    bad_prev = bad;
    p_hold_if = if_valid && !if_ready && !redir;
    p_pc = if_pc;
    p_inst = if_inst;
    p_hold_req = imem_req_valid && !imem_req_ready && !redir;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rst = rst_v;
    if_ready = ifr_v;
    ex_valid = nx_valid;
    ex_is_branch = nx_br;
    ex_is_jump = nx_jmp;
    take_branch = nx_take;
    ex_target = nx_tgt;
    nx_valid = 0;
    imem_resp_valid = 1'b0;
    if (mem_wait > 0) begin
      mem_wait--;
      if (mem_wait == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data = mem_word(mem_addr);
      end
    end
    imem_req_ready = hold_rdy ? 1'b0 : (rdy_rand ? ($urandom % 4 != 0) : 1'b1);
    @(negedge clk);
    monitor();
  endtask

  task automatic wait_acc(output logic [31:0] a);
    bit ok;
    ok = 0;
    a = 32'h0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (imem_req_valid && imem_req_ready) begin
        ok = 1;
        a = imem_req_addr;
        break;
      end
    end
    check("acc_timeout", 32'(ok), 32'h1);
  endtask

  task automatic chk_reset();
    check("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("rst_if_valid", 32'(if_valid), 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_inst", if_inst, 32'h0000_0013);
    check("rst_mis", 32'(fetch_misaligned), 32'h0);
    check("rst_mis_addr", misaligned_addr, 32'h0);
  endtask

  task automatic jump_to(input logic [31:0] t, input bit br);
    nx_valid = 1;
    nx_br = br;
    nx_jmp = !br;
    nx_take = 1;
    nx_tgt = t;
  endtask

  logic [31:0] a0, a1, pc0;
  bit          seen;

  initial begin
    rst = 1; ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0;
    take_branch = 0; ex_target = 0; imem_req_ready = 0;
    imem_resp_valid = 0; imem_resp_data = 0; if_ready = 1;

    // reset, then sequential fetch with 1-cycle memory
    repeat (3) tick();
    chk_reset();
    rst_v = 0;
    dq_pc.delete();
    dq_cyc.delete();
    tick();
    check("first_req_late", 32'(imem_req_valid), 32'h0);
    tick();
    check("first_req", 32'(imem_req_valid), 32'h1);
    check("first_addr", imem_req_addr, 32'h0);
    repeat (9) tick();
    check("seq_count", 32'(dq_pc.size() >= 3), 32'h1);
    if (dq_pc.size() >= 3) begin
      check("seq_pc0", dq_pc[0], 32'h0);
      check("seq_pc1", dq_pc[1], 32'h4);
      check("seq_pc2", dq_pc[2], 32'h8);
      check("seq_gap1", 32'(dq_cyc[1] - dq_cyc[0]), 32'd3);
      check("seq_gap2", 32'(dq_cyc[2] - dq_cyc[1]), 32'd3);
    end

    // decode stall in the full buffer
    ifr_v = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (if_valid && !if_ready) begin
        seen = 1;
        break;
      end
    end
    check("stall_reached", 32'(seen), 32'h1);
    pc0 = if_pc;
    repeat (5) tick();
    check("stall_valid", 32'(if_valid), 32'h1);
    check("stall_pc", if_pc, pc0);
    check("stall_noreq", 32'(imem_req_valid), 32'h0);
    ifr_v = 1;
    wait_acc(a0);
    check("stall_next", a0, pc0 + 32'd4);

    // taken branch while waiting for memory
    mem_lat = 3;
    wait_acc(a0);
    jump_to(32'h100, 1);
    tick();
    check("br_wait_flush", 32'(if_flush), 32'h1);
    wait_acc(a0);
    check("br_wait_target", a0, 32'h100);

    // not-taken branch leaves the sequence alone
    wait_acc(a0);
    jump_to(32'h300, 1);
    nx_take = 0;
    tick();
    check("nt_flush", 32'(if_flush), 32'h0);
    wait_acc(a1);
    check("nt_seq", a1, a0 + 32'd4);

    // redirect coinciding with the request handshake
    mem_lat = 1;
    hold_rdy = 1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (imem_req_valid && !imem_req_ready) begin
        seen = 1;
        break;
      end
    end
    check("co_reached", 32'(seen), 32'h1);
    jump_to(32'h200, 0);
    hold_rdy = 0;
    tick();
    check("co_flush", 32'(if_flush), 32'h1);
    check("co_fire", 32'(imem_req_valid && imem_req_ready), 32'h1);
    wait_acc(a0);
    check("co_target", a0, 32'h200);

    // misaligned jump target
    jump_to(32'h102, 0);
    tick();
    check("mis_noflush", 32'(if_flush), 32'h0);
    tick();
    check("mis_pulse_hi", 32'(fetch_misaligned), 32'h1);
    check("mis_addr_val", misaligned_addr, 32'h102);
    tick();
    check("mis_pulse_lo", 32'(fetch_misaligned), 32'h0);
    check("mis_addr_held", misaligned_addr, 32'h102);

    // PC wrap at the top of the address space
    jump_to(32'hFFFF_FFFC, 0);
    tick();
    wait_acc(a0);
    check("wrap_top", a0, 32'hFFFF_FFFC);
    wait_acc(a1);
    check("wrap_zero", a1, 32'h0);

    // reset in the middle of a memory wait
    mem_lat = 3;
    wait_acc(a0);
    rst_v = 1;
    hold_rdy = 1;
    tick();
    tick();
    chk_reset();
    rst_v = 0;
    tick();
    check("stale_resp_seen", 32'(imem_resp_valid), 32'h1);
    tick();
    check("stale_ignored", 32'(if_valid), 32'h0);
    check("post_rst_req", 32'(imem_req_valid), 32'h1);
    hold_rdy = 0;
    mem_lat = 1;
    wait_acc(a0);
    check("post_rst_pc", a0, 32'h0);
    repeat (3) tick();

    // random traffic
    mem_lat = 0;
    rdy_rand = 1;
    n_deliv = 0;
    for (int i = 0; i < 1500; i++) begin
      int r;
      ifr_v = ($urandom % 3 != 0);
      nx_valid = ($urandom % 8 == 0);
      nx_br = $urandom % 2;
      nx_jmp = $urandom % 2;
      nx_take = $urandom % 2;
      r = int'($urandom % 16);
      if (r == 0) nx_tgt = 32'hFFFF_FFFC;
      else if (r == 1) nx_tgt = (32'($urandom_range(0, 255)) << 2) | 32'd2;
      else nx_tgt = 32'($urandom_range(0, 1023)) << 2;
      tick();
    end
    check("rand_progress", 32'(n_deliv > 50), 32'h1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
